// File: rtl/stochastic_sampler.sv
// stochastic_sampler
//   Collects NUM_UNITS Bernoulli samples, one per accepted probability, and
//   packs them into a word. Each sample is 1 when rand_in < prob_in.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin a batch (honoured only in IDLE)
//   rand_in               : uniform random operand, fresh every cycle
//   prob_in / prob_valid  : firing probability (2^DATA_WIDTH == 1.0), valid flag
//   prob_ready            : sampler is accepting probabilities
//   sample_word           : packed unit states of the last completed batch
//   ones_count            : population count of sample_word
//   out_valid / out_ready : output handshake
//   busy                  : state machine is not IDLE
//
// state  | meaning
// IDLE   | waiting for start
// SAMPLE | accepting prob_in transfers, one sample bit each
// OUTPUT | presenting the completed word until out_ready
module stochastic_sampler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          rand_in,
  input  logic [DATA_WIDTH-1:0]          prob_in,
  input  logic                           prob_valid,
  output logic                           prob_ready,
  output logic [NUM_UNITS-1:0]           sample_word,
  output logic [$clog2(NUM_UNITS+1)-1:0] ones_count,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int CW = $clog2(NUM_UNITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_UNITS-1:0] word_q, word_d;
  logic [CW-1:0]        ones_q, ones_d;
  logic [NUM_UNITS-1:0] sample_word_q, sample_word_d;
  logic [CW-1:0]        ones_count_q, ones_count_d;
  logic                 out_valid_q, out_valid_d;

  logic                 samp_bit;
  logic                 xfer;
  logic                 last_xfer;

  assign samp_bit  = (rand_in < prob_in);
  assign xfer      = (state_q == SAMPLE) && prob_valid;
  assign last_xfer = xfer && (cnt_q == CW'(NUM_UNITS - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    ones_d        = ones_q;
    sample_word_d = sample_word_q;
    ones_count_d  = ones_count_q;
    out_valid_d   = out_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = '0;
          word_d  = '0;
          ones_d  = '0;
        end
      end
      SAMPLE: begin
        if (xfer) begin
          // Loop-based bit insert keeps the index width independent of CW.
          for (int i = 0; i < NUM_UNITS; i++) begin
            if (cnt_q == CW'(i)) word_d[i] = samp_bit;
          end
          ones_d = ones_q + CW'(samp_bit);
          cnt_d  = cnt_q + CW'(1);
          if (last_xfer) begin
            state_d       = OUTPUT;
            sample_word_d = word_d;
            ones_count_d  = ones_d;
            out_valid_d   = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      word_q        <= '0;
      ones_q        <= '0;
      sample_word_q <= '0;
      ones_count_q  <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      ones_q        <= ones_d;
      sample_word_q <= sample_word_d;
      ones_count_q  <= ones_count_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign prob_ready  = (state_q == SAMPLE);
  assign busy        = (state_q != IDLE);
  assign sample_word = sample_word_q;
  assign ones_count  = ones_count_q;
  assign out_valid   = out_valid_q;

endmodule
